decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Second stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage.
- Consumes the IF/ID register outputs (InstrD, PCD, PCPlus4D).
- Contains the 32x32 integer register file (written by writeback), the main/ALU control decoder and the immediate extender.
- Ends in the ID/EX pipeline register, which the hazard unit can flush with FlushE.

Parameters:
XLEN, 32, datapath and register width
NREGS, 32, register file depth; index width is log2(NREGS)=5

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high
InstrD  in  32  instruction from IF/ID
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
RegWriteW  in  1  writeback enable
RdW  in  5  writeback destination
ResultW  in  32  writeback data
FlushE  in  1  synchronous bubble insert into ID/EX (load-use stall or taken branch/jump)
Rs1D  out  5  InstrD[19:15], combinational, for the hazard unit
Rs2D  out  5  InstrD[24:20], combinational
RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered controls
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RD1E, RD2E  out  32  registered operands
ImmExtE  out  32  registered extended immediate
Rs1E, Rs2E, RdE  out  5 each  registered register indices
PCE, PCPlus4E  out  32  registered PC values

Behaviour:
- Reset (async):
  - All 31 writable registers clear to 0.
  - All ID/EX outputs clear to 0, which is a bubble.
- Register file:
  - x0 reads 0 always. A write to x0 is ignored.
  - Write on the rising edge when RegWriteW=1 and RdW!=0.
  - Write-through: if RegWriteW=1, RdW!=0 and RdW equals the read index, the read port returns ResultW in the same cycle, not the stale value.
- Decode (combinational on InstrD), driving RegWrite/ImmSrc/ALUSrc/MemWrite/ResultSrc/Branch/ALUOp/Jump:
  - 0000011 lw: 1/00/1/0/01/0/00/0
  - 0100011 sw: 0/01/1/1/xx->00/0/00/0
  - 0110011 R-type: 1/xx->00/0/0/00/0/10/0
  - 1100011 beq: 0/10/0/0/00/1/01/0
  - 0010011 I-ALU: 1/00/1/0/00/0/10/0
  - 1101111 jal: 1/11/0/0/10/0/00/1
  - Any other opcode, including 0x00000000 (the reset value of IF/ID): all controls 0, i.e. a bubble.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 uses funct3:
    - 000: sub if funct7[5]=1 and op[5]=1 (R-type only), else add.
    - 010 -> slt; 110 -> or; 111 -> and.
    - Other funct3 -> add.
- Immediate, sign-extended from InstrD[31]:
  - I = {20{i31}, i[31:20]}
  - S = {20{i31}, i[31:25], i[11:7]}
  - B = {19{i31}, i31, i7, i[30:25], i[11:8], 0}
  - J = {11{i31}, i31, i[19:12], i20, i[30:21], 0}
- ID/EX register:
  - Latency 1 cycle.
  - On the rising edge with FlushE=1, all outputs load 0 (controls and data), regardless of InputD.
  - Otherwise all outputs load their D-stage values.
  - There is no stall input: a load-use stall holds IF/ID upstream while FlushE bubbles EX.
- Simultaneous events:
  - Reset dominates FlushE and writeback.
  - A writeback to the same register being read in that cycle is bypassed as above.
  - Reset asserted mid-operation clears state immediately; the first instruction after release decodes normally.

Test Plan:
- Reset asserted with InstrD=0x00000000 -> all E outputs 0, RD1 of every register 0. After release, decoding 0x00000000 still yields all-zero controls.
- Write x5=0xDEADBEEF via W-port, then InstrD=0x00528333 (add x6,x5,x5) -> next edge RD1E=RD2E=0xDEADBEEF, RegWriteE=1, ALUControlE=000, RdE=6, Rs1E=Rs2E=5.
- Same cycle: RegWriteW=1, RdW=7, ResultW=0x12345678 and InstrD reads x7 -> RD1E=0x12345678 (write-through). A write of 0xFFFFFFFF to x0 -> subsequent x0 reads give 0.
- Immediates:
  - lw 0xFFC02083 -> ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1.
  - sw 0xFE112E23 -> ImmExtE=0xFFFFFFFC, MemWriteE=1, RegWriteE=0.
  - beq 0xFE000EE3 -> ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=001.
  - jal 0x008000EF -> ImmExtE=0x00000008, JumpE=1, ResultSrcE=10.
- Flush: valid R-type with FlushE=1 -> next edge all controls and data 0. With FlushE=0 the following cycle, the instruction propagates normally.
- ALU decode:
  - sub 0x40B50533 -> 001
  - slt 0x00B52533 -> 101
  - or 0x00B56533 -> 011
  - and 0x00B57533 -> 010
  - addi with imm bit 30 set (0x40050513) -> 000 (add, not sub)

Source files
------------

// File: rtl/decode_stage_if.sv
// IF/ID-side inputs, writeback port and ID/EX outputs of the decode stage.
// The slave modport is the decode stage's own view of the bundle.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic            FlushE;

  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic            RegWriteE;
  logic            MemWriteE;
  logic            JumpE;
  logic            BranchE;
  logic            ALUSrcE;
  logic [1:0]      ResultSrcE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE,
           PCE, PCPlus4E
  );

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE,
           PCE, PCPlus4E
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register file with write-through, main/ALU decoder,
// immediate extender and the flushable ID/EX pipeline register.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic           clock,
  input logic           reset,
  decode_stage_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } idex_t;

  logic [XLEN-1:0] instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic [AW-1:0]   rd_w;
  logic            wr_en;

  assign instr  = bus.InstrD;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];
  assign rd_w   = bus.RdW;
  assign wr_en  = bus.RegWriteW && (rd_w != '0);

  assign bus.Rs1D = rs1;
  assign bus.Rs2D = rs2;

  // Register file; x0 is never written so it stays at its reset value of 0.
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[rd_w] = bus.ResultW;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  // Same-cycle writeback to the register being read is forwarded here.
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != '0) rd1 = (wr_en && rd_w == rs1) ? bus.ResultW : regs_q[rs1];
    if (rs2 != '0) rd2 = (wr_en && rd_w == rs2) ? bus.ResultW : regs_q[rs2];
  end

  logic       reg_write;
  logic       mem_write;
  logic       jump;
  logic       branch;
  logic       alu_src;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [1:0] alu_op;

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    result_src = 2'b00;
    imm_src    = 2'b00;
    alu_op     = 2'b00;
    unique case (opcode)
      OP_LOAD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
      end
      OP_STORE: begin
        imm_src   = 2'b01;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_RTYPE: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      OP_BRANCH: begin
        imm_src = 2'b10;
        branch  = 1'b1;
        alu_op  = 2'b01;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b10;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        imm_src    = 2'b11;
        result_src = 2'b10;
        jump       = 1'b1;
      end
      default: ;
    endcase
  end

  // Only R-type may subtract on funct3=000; addi keeps imm bit 30 as data.
  logic [2:0] alu_control;

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (instr[30] && opcode[5]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  logic [XLEN-1:0] imm_ext;

  always_comb begin
    imm_ext = '0;
    unique case (imm_src)
      2'b00: imm_ext = {{20{instr[31]}}, instr[31:20]};
      2'b01: imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      2'b10: imm_ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      2'b11: imm_ext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // ID/EX register; a flush loads an all-zero bubble, data included.
  idex_t idex_d;
  idex_t idex_q;

  always_comb begin
    idex_d = '0;
    if (!bus.FlushE) begin
      idex_d.reg_write   = reg_write;
      idex_d.mem_write   = mem_write;
      idex_d.jump        = jump;
      idex_d.branch      = branch;
      idex_d.alu_src     = alu_src;
      idex_d.result_src  = result_src;
      idex_d.alu_control = alu_control;
      idex_d.rd1         = rd1;
      idex_d.rd2         = rd2;
      idex_d.imm_ext     = imm_ext;
      idex_d.rs1         = rs1;
      idex_d.rs2         = rs2;
      idex_d.rd          = rd;
      idex_d.pc          = bus.PCD;
      idex_d.pc_plus4    = bus.PCPlus4D;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign bus.RegWriteE   = idex_q.reg_write;
  assign bus.MemWriteE   = idex_q.mem_write;
  assign bus.JumpE       = idex_q.jump;
  assign bus.BranchE     = idex_q.branch;
  assign bus.ALUSrcE     = idex_q.alu_src;
  assign bus.ResultSrcE  = idex_q.result_src;
  assign bus.ALUControlE = idex_q.alu_control;
  assign bus.RD1E        = idex_q.rd1;
  assign bus.RD2E        = idex_q.rd2;
  assign bus.ImmExtE     = idex_q.imm_ext;
  assign bus.Rs1E        = idex_q.rs1;
  assign bus.Rs2E        = idex_q.rs2;
  assign bus.RdE         = idex_q.rd;
  assign bus.PCE         = idex_q.pc;
  assign bus.PCPlus4E    = idex_q.pc_plus4;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage, checked against an instruction-level
// model of the register file, decoder and immediate formats.
module tb_decode_stage;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
  } idex_t;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] SLT = 3'b101;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] model_rf [32];
  logic [31:0] pc_ctr = 32'h0000_1000;

  always #5 clock = ~clock;

  decode_stage_if bus_if ();

  decode_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %08h, expected %08h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [2:0] alu_for(input logic [2:0] f3, input logic is_sub);
    case (f3)
      3'd0:    return is_sub ? SUB : ADD;
      3'd2:    return SLT;
      3'd6:    return OR;
      3'd7:    return AND;
      default: return ADD;
    endcase
  endfunction

  // Controls and immediate of one instruction, straight from the ISA tables.
  function automatic idex_t decode_model(input logic [31:0] instr);
    idex_t e = '0;
    int s = int'(instr);
    int i_imm = s >>> 20;
    int s_imm = (s >>> 25) * 32 + int'(instr[11:7]);
    int b_imm = int'(instr[7]) * 2048 + int'(instr[30:25]) * 32
              + int'(instr[11:8]) * 2 - int'(instr[31]) * 4096;
    int j_imm = int'(instr[19:12]) * 4096 + int'(instr[20]) * 2048
              + int'(instr[30:21]) * 2 - int'(instr[31]) * (1 << 20);
    e.imm = 32'(i_imm);
    case (instr[6:0])
      7'h03: begin e.reg_write = 1; e.alu_src = 1; e.result_src = 2'd1; end
      7'h23: begin e.mem_write = 1; e.alu_src = 1; e.imm = 32'(s_imm); end
      7'h33: begin e.reg_write = 1; e.alu_control = alu_for(instr[14:12], instr[30]); end
      7'h63: begin e.branch = 1; e.alu_control = SUB; e.imm = 32'(b_imm); end
      7'h13: begin e.reg_write = 1; e.alu_src = 1; e.alu_control = alu_for(instr[14:12], 1'b0); end
      7'h6f: begin e.reg_write = 1; e.jump = 1; e.result_src = 2'd2; e.imm = 32'(j_imm); end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] read_model(input logic [4:0] idx, input logic rw,
                                             input logic [4:0] rdw, input logic [31:0] res);
    if (idx == 5'd0) return 32'h0;
    if (rw && rdw == idx) return res;
    return model_rf[idx];
  endfunction

  task automatic compareAll(input idex_t e);
    checkOutput("RegWriteE",   32'(bus_if.RegWriteE),   32'(e.reg_write));
    checkOutput("MemWriteE",   32'(bus_if.MemWriteE),   32'(e.mem_write));
    checkOutput("JumpE",       32'(bus_if.JumpE),       32'(e.jump));
    checkOutput("BranchE",     32'(bus_if.BranchE),     32'(e.branch));
    checkOutput("ALUSrcE",     32'(bus_if.ALUSrcE),     32'(e.alu_src));
    checkOutput("ResultSrcE",  32'(bus_if.ResultSrcE),  32'(e.result_src));
    checkOutput("ALUControlE", 32'(bus_if.ALUControlE), 32'(e.alu_control));
    checkOutput("ImmExtE",     bus_if.ImmExtE,          e.imm);
    checkOutput("RD1E",        bus_if.RD1E,             e.rd1);
    checkOutput("RD2E",        bus_if.RD2E,             e.rd2);
    checkOutput("Rs1E",        32'(bus_if.Rs1E),        32'(e.rs1));
    checkOutput("Rs2E",        32'(bus_if.Rs2E),        32'(e.rs2));
    checkOutput("RdE",         32'(bus_if.RdE),         32'(e.rd));
    checkOutput("PCE",         bus_if.PCE,              e.pc);
    checkOutput("PCPlus4E",    bus_if.PCPlus4E,         e.pc4);
  endtask

  // Called at a falling edge; returns at the next falling edge with the
  // ID/EX outputs for this instruction already compared.
  task automatic applyStimulus(input logic [31:0] instr, input logic rw,
                               input logic [4:0] rdw, input logic [31:0] res,
                               input logic flush);
    idex_t e;
    bus_if.InstrD    = instr;
    bus_if.PCD       = pc_ctr;
    bus_if.PCPlus4D  = pc_ctr + 32'd4;
    bus_if.RegWriteW = rw;
    bus_if.RdW       = rdw;
    bus_if.ResultW   = res;
    bus_if.FlushE    = flush;
    #1;
    checkOutput("Rs1D", 32'(bus_if.Rs1D), 32'(instr[19:15]));
    checkOutput("Rs2D", 32'(bus_if.Rs2D), 32'(instr[24:20]));
    e = decode_model(instr);
    e.rd1 = read_model(instr[19:15], rw, rdw, res);
    e.rd2 = read_model(instr[24:20], rw, rdw, res);
    e.rs1 = instr[19:15];
    e.rs2 = instr[24:20];
    e.rd  = instr[11:7];
    e.pc  = pc_ctr;
    e.pc4 = pc_ctr + 32'd4;
    if (flush) e = '0;
    @(posedge clock);
    if (rw && rdw != 5'd0) model_rf[rdw] = res;
    pc_ctr = pc_ctr + 32'd4;
    @(negedge clock);
    compareAll(e);
  endtask

  task automatic randomCycle();
    logic [31:0] instr = $urandom;
    logic [6:0]  ops [7] = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h6f, 7'h00};
    int          sel = $urandom_range(0, 7);
    logic        rw = 1'($urandom_range(0, 1));
    logic [4:0]  rdw = 5'($urandom);
    if (sel < 7) instr[6:0] = ops[sel];
    if ($urandom_range(0, 2) == 0) rdw = instr[19:15];
    applyStimulus(instr, rw, rdw, $urandom, $urandom_range(0, 7) == 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    reset = 1'b1;
    bus_if.InstrD = 32'h0; bus_if.PCD = 32'h0; bus_if.PCPlus4D = 32'h0;
    bus_if.RegWriteW = 1'b0; bus_if.RdW = 5'd0; bus_if.ResultW = 32'h0;
    bus_if.FlushE = 1'b0;
    repeat (2) @(negedge clock);
    compareAll('0);
    reset = 1'b0;

    applyStimulus(32'h0000_0000, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("zero_instr_regwrite", 32'(bus_if.RegWriteE), 32'h0);
    for (int i = 0; i < 32; i++)
      applyStimulus({7'b0, 5'(i), 5'(i), 3'b000, 5'd1, 7'h33}, 1'b0, 5'd0, 32'h0, 1'b0);

    applyStimulus(32'h0000_0000, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(32'h0052_8333, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("add_rd1", bus_if.RD1E, 32'hDEAD_BEEF);
    checkOutput("add_rd2", bus_if.RD2E, 32'hDEAD_BEEF);
    checkOutput("add_rd",  32'(bus_if.RdE), 32'd6);

    applyStimulus(32'h0003_8433, 1'b1, 5'd7, 32'h1234_5678, 1'b0);
    checkOutput("wthru_rd1", bus_if.RD1E, 32'h1234_5678);
    applyStimulus(32'h0000_0000, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(32'h0000_00B3, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("x0_rd1", bus_if.RD1E, 32'h0);

    applyStimulus(32'hFFC0_2083, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("lw_imm", bus_if.ImmExtE, 32'hFFFF_FFFC);
    applyStimulus(32'hFE11_2E23, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("sw_imm", bus_if.ImmExtE, 32'hFFFF_FFFC);
    applyStimulus(32'hFE00_0EE3, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("beq_imm", bus_if.ImmExtE, 32'hFFFF_FFFC);
    checkOutput("beq_alu", 32'(bus_if.ALUControlE), 32'(SUB));
    applyStimulus(32'h0080_00EF, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("jal_imm", bus_if.ImmExtE, 32'h0000_0008);
    checkOutput("jal_src", 32'(bus_if.ResultSrcE), 32'd2);

    applyStimulus(32'h0052_8333, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("flush_rd1", bus_if.RD1E, 32'h0);
    applyStimulus(32'h0052_8333, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("post_flush_rd1", bus_if.RD1E, 32'hDEAD_BEEF);

    applyStimulus(32'h40B5_0533, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("alu_sub", 32'(bus_if.ALUControlE), 32'(SUB));
    applyStimulus(32'h00B5_2533, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("alu_slt", 32'(bus_if.ALUControlE), 32'(SLT));
    applyStimulus(32'h00B5_6533, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("alu_or", 32'(bus_if.ALUControlE), 32'(OR));
    applyStimulus(32'h00B5_7533, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("alu_and", 32'(bus_if.ALUControlE), 32'(AND));
    applyStimulus(32'h4005_0513, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("alu_addi", 32'(bus_if.ALUControlE), 32'(ADD));

    repeat (400) randomCycle();

    // Asynchronous reset between edges must clear state immediately.
    bus_if.InstrD = 32'h0052_8333;
    bus_if.FlushE = 1'b0;
    reset = 1'b1;
    #1;
    compareAll('0);
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(32'h0052_8333, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("post_reset_rd1", bus_if.RD1E, 32'h0);
    checkOutput("post_reset_regwrite", 32'(bus_if.RegWriteE), 32'h1);
    repeat (100) randomCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
